tick_slot_scheduler: RTL

- Owns one mod-MAXIMUM_VALUE tick counter and time-shares it between NUM_REQ requesters.
- Each granted requester holds the counter for a programmed number of full wrap periods, then receives a done pulse.
- Sits between client blocks that need timed windows and the shared counting datapath.
- Provides round-robin arbitration, per-grant period counting, abort on request drop, and zero/max flags of the shared counter.

---
 rtl/tick_slot_scheduler_if.sv | 29 ++
 rtl/tick_slot_scheduler.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/tick_slot_scheduler_if.sv
// Bundle between the requesting clients (master) and tick_slot_scheduler (slave):
// request/period inputs plus grant, completion and shared-counter outputs.
interface tick_slot_scheduler_if #(
  parameter int NUM_REQ           = 4,
  parameter int NBITS_FOR_REPS    = 4,
  parameter int NBITS_FOR_COUNTER = 5,
  parameter int NBITS_FOR_ID      = 2
);
  logic                              enable;
  logic [NUM_REQ-1:0]                req;
  logic [NUM_REQ*NBITS_FOR_REPS-1:0] reps_in;
  logic [NUM_REQ-1:0]                grant;
  logic                              busy;
  logic                              done;
  logic [NBITS_FOR_ID-1:0]           done_id;
  logic [NBITS_FOR_COUNTER-1:0]      count;
  logic                              flag0;
  logic                              flagmax;

  modport master (
    output enable, req, reps_in,
    input  grant, busy, done, done_id, count, flag0, flagmax
  );

  modport slave (
    input  enable, req, reps_in,
    output grant, busy, done, done_id, count, flag0, flagmax
  );
endinterface

// File: rtl/tick_slot_scheduler.sv
// Time-shares one mod-MAXIMUM_VALUE tick counter between NUM_REQ requesters.
// Define SCHED_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module tick_slot_scheduler #(
  parameter int MAXIMUM_VALUE  = 32,
  parameter int NUM_REQ        = 4,
  parameter int NBITS_FOR_REPS = 4
) (
  input logic                   clk,
  input logic                   reset,
  tick_slot_scheduler_if.slave  bus
);
  function automatic int CeilLog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  localparam int NBITS_FOR_COUNTER = CeilLog2(MAXIMUM_VALUE);
  localparam int NBITS_FOR_ID      = CeilLog2(NUM_REQ);
  localparam logic [NBITS_FOR_COUNTER-1:0] COUNT_LAST = NBITS_FOR_COUNTER'(MAXIMUM_VALUE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                       state, state_next;
  logic [NBITS_FOR_COUNTER-1:0] count;
  logic [NBITS_FOR_REPS-1:0]    remaining, reps_pick;
  logic [NBITS_FOR_ID-1:0]      winner, pick, owner;
  logic                         pick_valid, abort, wrap, final_wrap;
  logic [NUM_REQ-1:0]           grant, grant_next;
  logic                         busy, busy_next, done, done_next;
  logic [NBITS_FOR_ID-1:0]      done_id, done_id_next;

`ifdef SCHED_FIXED_PRIO_EN
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        pick       = NBITS_FOR_ID'(i);
        pick_valid = 1'b1;
      end
    end
  end
`else
  logic [NBITS_FOR_ID-1:0] last;
  int                      idx;

  // Scan downward in distance from last so the nearest requester after last wins.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    idx        = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = (int'(last) + i) % NUM_REQ;
      if (bus.req[idx]) begin
        pick       = NBITS_FOR_ID'(idx);
        pick_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         last <= NBITS_FOR_ID'(NUM_REQ - 1);
    else if (state == IDLE && pick_valid) last <= pick;
  end
`endif

  assign reps_pick  = bus.reps_in[int'(pick) * NBITS_FOR_REPS +: NBITS_FOR_REPS];
  assign abort      = !bus.req[winner];
  assign wrap       = bus.enable && (count == COUNT_LAST);
  assign final_wrap = wrap && (remaining == NBITS_FOR_REPS'(1));
  assign owner      = (state == IDLE) ? pick : winner;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Abort has priority over completion on the same edge.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_valid) state_next = RUN;
      RUN: begin
        if (abort)           state_next = IDLE;
        else if (final_wrap) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    grant_next   = '0;
    busy_next    = 1'b0;
    done_next    = 1'b0;
    done_id_next = done_id;
    case (state_next)
      RUN: begin
        grant_next = NUM_REQ'(1) << owner;
        busy_next  = 1'b1;
      end
      DONE: begin
        done_next    = 1'b1;
        done_id_next = winner;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_id   <= '0;
      count     <= '0;
      remaining <= '0;
      winner    <= '0;
    end else begin
      grant   <= grant_next;
      busy    <= busy_next;
      done    <= done_next;
      done_id <= done_id_next;
      case (state)
        IDLE: begin
          count <= '0;
          if (pick_valid) begin
            winner    <= pick;
            remaining <= (reps_pick == '0) ? NBITS_FOR_REPS'(1) : reps_pick;
          end
        end
        RUN: begin
          if (abort) begin
            count <= '0;
          end else if (bus.enable) begin
            if (count == COUNT_LAST) begin
              count <= '0;
              if (!final_wrap) remaining <= remaining - 1'b1;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        default: count <= '0;
      endcase
    end
  end

  assign bus.grant   = grant;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.done_id = done_id;
  assign bus.count   = count;
  assign bus.flag0   = (count == '0);
  assign bus.flagmax = (count == COUNT_LAST);
endmodule
